// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch stage; sequences Start/Done and counts RUN cycles.
// Latency: imem read is combinational, a branch redirects the PC on the next edge (no bubbles).
// Backpressure: stall holds PC, state and cycle counter; the opcode is still presented while stalled.
module fetch_unit #(
    parameter int                 PC_W      = 10,
    parameter int                 INSTR_W   = 9,
    parameter logic [INSTR_W-1:0] HALT_WORD = 9'h1FF,
    parameter int                 CNT_W     = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               stall,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               jump_en,
    input  logic               alu_branch,
    input  logic [PC_W-1:0]    lut_target,
    output logic [PC_W-1:0]    pc_out,
    output logic [4:0]         opcode,
    output logic [3:0]         operand,
    output logic               Done,
    output logic [CNT_W-1:0]   cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              is_halt;

    assign is_halt     = (instr_in == HALT_WORD);
    assign pc_out      = pc_q;
    assign Done        = done_q;
    assign cycle_count = cnt_q;

    // State, PC, counter and Done registers; reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state, next-PC and decoder outputs. HALT detection is checked before
    // the branch so a halt word can never redirect the PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        opcode  = 5'b00000;
        operand = 4'b0000;
        case (state_q)
            S_IDLE, S_HALT: begin
                // Start wins over stall outside RUN.
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                operand = instr_in[3:0];
                // The halt encoding is not a real opcode; keep the decoder on NOP.
                opcode  = is_halt ? 5'b00000 : instr_in[INSTR_W-1 -: 5];
                if (!stall) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (is_halt) begin
                        state_d = S_HALT;
                        done_d  = 1'b1;
                    end else if (jump_en && alu_branch) begin
                        pc_d = lut_target;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Decoder sees NOP in the same cycle reset is asserted.
        if (Reset) begin
            opcode  = 5'b00000;
            operand = 4'b0000;
        end
    end

endmodule
